// File: rtl/bias_bram_sched.sv
//------------------------------------------------------------------------------
// bias_bram_sched
//
// Purpose:
//   Sequencer and arbiter that owns the single-port bias BRAM. A run first
//   streams a bias vector from a valid/ready write stream into the BRAM, then
//   shares the BRAM read port between N_REQ PE-lane requesters using
//   round-robin arbitration. Read data is returned one cycle after the grant,
//   tagged with the lane ID and an out-of-range flag.
//
//   State sequence: IDLE -> LOAD -> SERVE -> DONE -> IDLE
//   (LOAD is skipped when the requested word count is zero).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_run                 start pulse, only honoured in IDLE
//   i_num_cnt             number of bias words to load (clamped to MEM_SIZE)
//   i_stop                ends the serve phase
//   s_valid/s_ready/s_data  bias write stream
//   i_req, i_req_addr     per-lane read request (level) and packed addresses
//   o_gnt                 one-hot combinational grant
//   o_rvalid, o_rid, o_rdata, o_rerr  read return, one cycle after grant
//   addr0, ce0, we0, d0, q0  BRAM port (q0 has 1-cycle read latency)
//   o_idle, o_load, o_serve, o_done  one-hot state flags
//   o_perf_gnt, o_perf_stall  performance counters
//
// Configuration macro:
//   BIAS_SCHED_PERF_EN - when defined, o_perf_gnt counts SERVE grants and
//   o_perf_stall counts SERVE cycles with an ungranted request, both 16-bit
//   saturating. When undefined both ports are tied to zero.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module bias_bram_sched #(
    parameter int MEM_SIZE = 49,
    parameter int AWIDTH   = 6,
    parameter int B_BW     = 8,
    parameter int N_REQ    = 4,
    parameter int IDW      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    i_run,
    input  logic [AWIDTH:0]         i_num_cnt,
    input  logic                    i_stop,

    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [B_BW-1:0]         s_data,

    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*AWIDTH-1:0] i_req_addr,
    output logic [N_REQ-1:0]        o_gnt,
    output logic                    o_rvalid,
    output logic [IDW-1:0]          o_rid,
    output logic [B_BW-1:0]         o_rdata,
    output logic                    o_rerr,

    output logic [AWIDTH-1:0]       addr0,
    output logic                    ce0,
    output logic                    we0,
    output logic [B_BW-1:0]         d0,
    input  logic [B_BW-1:0]         q0,

    output logic                    o_idle,
    output logic                    o_load,
    output logic                    o_serve,
    output logic                    o_done,

    output logic [15:0]             o_perf_gnt,
    output logic [15:0]             o_perf_stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SERVE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AWIDTH:0] L_MEM_SIZE = (AWIDTH+1)'(MEM_SIZE);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [AWIDTH:0]    r_num;
    logic [AWIDTH:0]    r_wr_cnt;
    logic [IDW-1:0]     r_rr_ptr;
    logic               r_rvalid;
    logic [IDW-1:0]     r_rid;
    logic               r_rerr;

    logic [AWIDTH:0]    w_num_clamped;
    logic               w_req_any;
    logic [IDW-1:0]     w_gnt_idx;
    logic               w_gnt_en;
    logic [AWIDTH-1:0]  w_gnt_addr;
    logic               w_wr_fire;
    logic               w_wr_last;

    // Requested word count is limited to the physical BRAM depth.
    assign w_num_clamped = (i_num_cnt > L_MEM_SIZE) ? L_MEM_SIZE : i_num_cnt;

    // Write handshake bookkeeping during LOAD; s_ready is 1 throughout LOAD,
    // so a write fires on every s_valid cycle in that state.
    assign w_wr_fire = (r_state == S_LOAD) && s_valid;
    assign w_wr_last = w_wr_fire && (r_wr_cnt == (r_num - 1'b1));

    // Round-robin search: walk the lanes starting at the pointer and pick the
    // first one requesting. N_REQ is a power of two, so the IDW-bit sum wraps
    // naturally modulo N_REQ.
    always_comb begin
        logic [IDW-1:0] v_cand;
        w_req_any = 1'b0;
        w_gnt_idx = '0;
        v_cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            v_cand = r_rr_ptr + IDW'(i);
            if (!w_req_any && i_req[v_cand]) begin
                w_req_any = 1'b1;
                w_gnt_idx = v_cand;
            end
        end
    end

    // A grant is only issued in SERVE, and i_stop suppresses it so that the
    // stop cycle never starts a new BRAM read.
    assign w_gnt_en   = (r_state == S_SERVE) && !i_stop && w_req_any;
    assign w_gnt_addr = i_req_addr[w_gnt_idx*AWIDTH +: AWIDTH];
    assign o_gnt      = w_gnt_en ? (N_REQ'(1) << w_gnt_idx) : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and BRAM port drive. The BRAM is only enabled on an
    // accepted stream word in LOAD or on a granted read in SERVE.
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        ce0         = 1'b0;
        we0         = 1'b0;
        addr0       = '0;
        d0          = '0;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_state_nxt = (w_num_clamped == '0) ? S_SERVE : S_LOAD;
                end
            end
            S_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    ce0   = 1'b1;
                    we0   = 1'b1;
                    addr0 = r_wr_cnt[AWIDTH-1:0];
                    d0    = s_data;
                end
                if (w_wr_last) begin
                    w_state_nxt = S_SERVE;
                end
            end
            S_SERVE: begin
                if (i_stop) begin
                    w_state_nxt = S_DONE;
                end else if (w_gnt_en) begin
                    ce0   = 1'b1;
                    addr0 = w_gnt_addr;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Word count and write pointer. The count is latched once per run and
    // cleared again in DONE so the next run starts from a clean value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num    <= '0;
            r_wr_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_run) begin
                        r_num    <= w_num_clamped;
                        r_wr_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_wr_last) begin
                        r_wr_cnt <= '0;
                    end else if (w_wr_fire) begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_num <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Round-robin pointer moves past the lane just granted. It is kept across
    // DONE so fairness carries over between runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_en) begin
            r_rr_ptr <= w_gnt_idx + IDW'(1);
        end
    end

    // Read return pipeline: rvalid mirrors "granted last cycle" so it lines up
    // with the BRAM read latency, independent of the state the FSM moved to.
    // The range check uses the latched count, so reads past the loaded words
    // are still issued but flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rerr   <= 1'b0;
        end else begin
            r_rvalid <= w_gnt_en;
            if (w_gnt_en) begin
                r_rid  <= w_gnt_idx;
                r_rerr <= ({1'b0, w_gnt_addr} >= r_num);
            end
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rid    = r_rid;
    assign o_rerr   = r_rerr;
    assign o_rdata  = q0;

    assign o_idle  = (r_state == S_IDLE);
    assign o_load  = (r_state == S_LOAD);
    assign o_serve = (r_state == S_SERVE);
    assign o_done  = (r_state == S_DONE);

`ifdef BIAS_SCHED_PERF_EN
    logic [15:0] r_perf_gnt;
    logic [15:0] r_perf_stall;
    logic        w_stall;

    // A stall cycle is any SERVE cycle in which at least one requesting lane
    // is left without a grant; it counts once regardless of how many lanes.
    assign w_stall = (r_state == S_SERVE) && (|(i_req & ~o_gnt));

    // Saturating counters, cleared when a new run is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_gnt   <= '0;
            r_perf_stall <= '0;
        end else if ((r_state == S_IDLE) && i_run) begin
            r_perf_gnt   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_gnt_en && (r_perf_gnt != 16'hFFFF)) begin
                r_perf_gnt <= r_perf_gnt + 16'd1;
            end
            if (w_stall && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign o_perf_gnt   = r_perf_gnt;
    assign o_perf_stall = r_perf_stall;
`else
    assign o_perf_gnt   = '0;
    assign o_perf_stall = '0;
`endif

endmodule
